// File: rtl/deck_controller.sv
// Card deck shuffler: LFSR-driven random swaps over an in-place deck.
// After a shuffle, cards are dealt one per draw request.
module deck_controller #(
    parameter int         N_CARDS = 20,
    parameter int         SWAPS   = 100,
    parameter int         SHIFTS  = 10,
    parameter logic [7:0] SEED    = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       seed_load,
    input  logic [7:0] seed_in,
    input  logic       draw_req,
    output logic       busy,
    output logic       ready,
    output logic       draw_valid,
    output logic [4:0] draw_card,
    output logic [4:0] cards_left,
    output logic       deck_empty
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT_A,
        SHIFT_B,
        SWAP,
        READY
    } state_t;

    localparam logic [7:0]  NC8       = 8'(N_CARDS);
    localparam logic [5:0]  NC6       = 6'(N_CARDS);
    localparam logic [15:0] SHIFTS_M1 = 16'(SHIFTS - 1);
    localparam logic [15:0] SWAPS_M1  = 16'(SWAPS - 1);
    localparam bit          NO_SWAPS  = (SWAPS == 0);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_nxt;
    logic [4:0]  deck [N_CARDS];
    logic [5:0]  ptr;
    logic [15:0] swap_cnt;
    logic [15:0] shift_cnt;
    logic [4:0]  from_idx;
    logic [4:0]  to_idx;
    logic        shift_last;
    logic        swap_last;
    logic        seed_ok;
    logic        can_draw;

    assign shift_last = (shift_cnt == SHIFTS_M1);
    assign swap_last  = (swap_cnt == SWAPS_M1);
    assign seed_ok    = seed_load && (state == IDLE || state == READY);
    assign can_draw   = (state == READY) && draw_req && !start && (ptr < NC6);

    // One LFSR step; the value after the current cycle's shift.
    always_comb begin
        lfsr_nxt = {lfsr[6:0], lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        ready      = 1'b0;
        cards_left = 5'd0;
        deck_empty = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = INIT;
            end
            INIT: begin
                busy      = 1'b1;
                state_nxt = NO_SWAPS ? READY : SHIFT_A;
            end
            SHIFT_A: begin
                busy = 1'b1;
                if (shift_last) state_nxt = SHIFT_B;
            end
            SHIFT_B: begin
                busy = 1'b1;
                if (shift_last) state_nxt = SWAP;
            end
            SWAP: begin
                busy      = 1'b1;
                state_nxt = swap_last ? READY : SHIFT_A;
            end
            READY: begin
                ready      = 1'b1;
                cards_left = 5'(NC6 - ptr);
                deck_empty = (ptr == NC6);
                if (start) state_nxt = INIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Deck, LFSR, counters and the draw port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr       <= SEED;
            ptr        <= 6'd0;
            swap_cnt   <= 16'd0;
            shift_cnt  <= 16'd0;
            from_idx   <= 5'd0;
            to_idx     <= 5'd0;
            draw_valid <= 1'b0;
            draw_card  <= 5'd0;
            for (int i = 0; i < N_CARDS; i++) deck[i] <= 5'(i);
        end else begin
            draw_valid <= 1'b0;
            if (seed_ok) begin
                lfsr <= (seed_in == 8'd0) ? 8'hFF : seed_in;
            end
            unique case (state)
                INIT: begin
                    ptr       <= 6'd0;
                    swap_cnt  <= 16'd0;
                    shift_cnt <= 16'd0;
                    for (int i = 0; i < N_CARDS; i++) deck[i] <= 5'(i);
                end
                SHIFT_A: begin
                    lfsr      <= lfsr_nxt;
                    shift_cnt <= shift_last ? 16'd0 : shift_cnt + 16'd1;
                    if (shift_last) from_idx <= 5'(lfsr_nxt % NC8);
                end
                SHIFT_B: begin
                    lfsr      <= lfsr_nxt;
                    shift_cnt <= shift_last ? 16'd0 : shift_cnt + 16'd1;
                    if (shift_last) to_idx <= 5'(lfsr_nxt % NC8);
                end
                SWAP: begin
                    deck[from_idx] <= deck[to_idx];
                    deck[to_idx]   <= deck[from_idx];
                    swap_cnt       <= swap_cnt + 16'd1;
                end
                READY: begin
                    if (can_draw) begin
                        draw_valid <= 1'b1;
                        draw_card  <= deck[ptr[4:0]];
                        ptr        <= ptr + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
